// File: rtl/toy_mem_responder.sv
// Word-addressed instruction/data memory stand-in for RISC_TOY; sticky ERR on out-of-range access.
// Latency: reads return one cycle after the sampling edge; writes land on the sampling edge.
// Backpressure: none, every request is accepted on its edge. Option: TOY_MEM_IFETCH_BYPASS_EN.
module toy_mem_responder #(
    parameter int AW        = 10,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        IREQ,
    input  logic [29:0] IADDR,
    output logic [31:0] INSTR,
    input  logic        DREQ,
    input  logic        DRW,
    input  logic [29:0] DADDR,
    input  logic [31:0] DWDATA,
    output logic [31:0] DRDATA,
    output logic        ERR,
    input  logic        ERR_CLR
);

    localparam int DEPTH = 1 << AW;

    // Time-zero contents only; the array is never touched by reset.
    logic [31:0] mem_q [DEPTH] = '{default: (INIT_ZERO ? 32'h0000_0000 : 32'hxxxx_xxxx)};

    logic [31:0] instr_q, instr_d;
    logic [31:0] drdata_q, drdata_d;
    logic        err_q, err_d;

    logic          i_inr, d_inr, wr_en;
    logic [AW-1:0] i_idx, d_idx;

    assign i_inr = (IADDR[29:AW] == '0);
    assign d_inr = (DADDR[29:AW] == '0);
    assign i_idx = IADDR[AW-1:0];
    assign d_idx = DADDR[AW-1:0];
    assign wr_en = DREQ & DRW & d_inr;

    always_comb begin
        instr_d  = instr_q;
        drdata_d = drdata_q;
        err_d    = ERR_CLR ? 1'b0 : err_q;

        if (IREQ) begin
            if (i_inr) begin
                instr_d = mem_q[i_idx];
`ifdef TOY_MEM_IFETCH_BYPASS_EN
                if (wr_en && (d_idx == i_idx))
                    instr_d = DWDATA;
`endif
            end else begin
                instr_d = 32'h0000_0000;
                err_d   = 1'b1;
            end
        end

        if (DREQ) begin
            if (!d_inr)
                err_d = 1'b1;
            if (!DRW)
                drdata_d = d_inr ? mem_q[d_idx] : 32'h0000_0000;
        end
    end

    // Array write shares the reset process so nothing is written while RSTN is low.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            instr_q  <= '0;
            drdata_q <= '0;
            err_q    <= 1'b0;
        end else begin
            instr_q  <= instr_d;
            drdata_q <= drdata_d;
            err_q    <= err_d;
            if (wr_en)
                mem_q[d_idx] <= DWDATA;
        end
    end

    assign INSTR  = instr_q;
    assign DRDATA = drdata_q;
    assign ERR    = err_q;

endmodule

// File: doc/toy_mem_responder.md
# toy_mem_responder

- Memory-side responder for the RISC_TOY core's instruction and data memory ports.
- Serves instruction fetches on one read port and loads/stores on a separate read/write port, both backed by one word-addressed storage array.
- Returns read data with a fixed one-cycle latency.
- Flags out-of-range accesses with a sticky error bit.
- Sits between the core and the testbench or SoC interconnect, standing in for instruction and data memory.

## Interface

Parameters:
- AW, 10, word-address bits decoded; array depth is 2**AW 32-bit words.
- INIT_ZERO, 1, when 1 the array is cleared to 0 at time zero (simulation init only); when 0 contents start unknown.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RSTN  input  1  asynchronous, active-low reset.
- IREQ  input  1  instruction read request, sampled on rising CLK.
- IADDR  input  30  instruction word address.
- INSTR  output  32  registered instruction read data.
- DREQ  input  1  data request, sampled on rising CLK.
- DRW  input  1  data direction: 1 = write, 0 = read.
- DADDR  input  30  data word address.
- DWDATA  input  32  data write value.
- DRDATA  output  32  registered data read data.
- ERR  output  1  sticky out-of-range flag.
- ERR_CLR  input  1  synchronous clear for ERR.

## Operation

- An address is in range when ADDR[29:AW] == 0. Index = ADDR[AW-1:0].
- **Instruction read** (IREQ=1 at an edge):
  - In range: INSTR <= mem[IADDR index].
  - Out of range: INSTR <= 32'h0000_0000 and ERR <= 1.
- **Data read** (DREQ=1, DRW=0):
  - In range: DRDATA <= mem[DADDR index].
  - Out of range: DRDATA <= 0 and ERR <= 1.
- **Data write** (DREQ=1, DRW=1):
  - In range: mem[index] <= DWDATA; DRDATA holds its previous value.
  - Out of range: write dropped, ERR <= 1.
- **Idle** (IREQ=0 or DREQ=0): the corresponding output holds its last value. No array access.
- **ERR_CLR=1**: ERR <= 0, unless an out-of-range access is sampled on the same edge. Set wins.
- **Same-edge data write and instruction read to the same in-range index**: behaviour is set by the Configuration macro.
- **Data read on the edge after a write to the same index**: returns the newly written value.
- Only one write source exists, so write/write conflicts cannot occur.

## Timing

- Reset (RSTN=0): INSTR=0, DRDATA=0, ERR=0, applied immediately without waiting for CLK.
  - No array writes occur while RSTN=0.
  - Array contents are retained across reset.
  - A request coinciding with the edge on which RSTN is low is discarded.
- First edge with RSTN=1: requests are serviced normally.
- Read latency is exactly 1 cycle for both ports:
  - Request sampled at edge N.
  - Data valid after edge N, held until the next request on that port.
- Write latency: the array updates at edge N. A read of that index sampled at edge N+1 or later returns the new data.
- ERR rises after the edge sampling the offending access. It stays 1 until an ERR_CLR edge with no new error.
- There is no back-pressure. Every request is accepted on the edge it is sampled.

## Configuration

- TOY_MEM_IFETCH_BYPASS_EN applies when a data write and an instruction read hit the same in-range index on the same edge.
  - Defined: INSTR <= DWDATA (write-first forwarding, for self-modifying code tests).
  - Undefined: INSTR <= the array's old contents (read-first).
- The macro does not affect any other case.

## Test plan

- Reset, then release with no requests -> INSTR=0, DRDATA=0, ERR=0. Assert RSTN=0 mid-run with DRDATA=32'h1234_5678 -> DRDATA=0 immediately.
- Write 32'hDEAD_BEEF to DADDR=5, then DREQ read of DADDR=5 on the next cycle -> DRDATA=32'hDEAD_BEEF one cycle after the read edge. IREQ with IADDR=5 -> INSTR=32'hDEAD_BEEF.
- Same-edge DREQ write 32'hCAFE_0001 to index 7 and IREQ IADDR=7, with mem[7]=32'h0000_0042:
  - INSTR=32'hCAFE_0001 with TOY_MEM_IFETCH_BYPASS_EN defined.
  - INSTR=32'h0000_0042 without it.
  - Either way, mem[7]=32'hCAFE_0001 afterward.
- AW=10, DREQ write to DADDR=30'h400 -> ERR=1 next cycle and mem[0] unchanged. IREQ with IADDR=30'h400 -> INSTR=0.
- ERR=1, then ERR_CLR=1 with no access -> ERR=0. ERR_CLR=1 on the same edge as an out-of-range DREQ read -> ERR stays 1.
- IREQ/DREQ low for 3 cycles after reads returning 32'h1111_1111 and 32'h2222_2222 -> INSTR and DRDATA hold those values.
